// File: rtl/aes_inv_cipher_ctrl.sv
// Valid/ready sequencer in front of aes_inv_cipher_top: key load, block decrypt, watchdog, block counter.
// Optional CBC chaining (IV port + chain register) is built when AES_INV_CTRL_CBC_EN is defined.
module aes_inv_cipher_ctrl #(
    parameter int TMO_CYCLES = 1023,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [127:0]      key_in,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [127:0]      din,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [127:0]      dout,
    output logic              busy,
    output logic              key_loaded,
    output logic              err_tmo,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic              core_kld,
    output logic              core_ld,
    output logic [127:0]      core_key,
    output logic [127:0]      core_text_in,
    input  logic              core_kdone,
    input  logic              core_done,
`ifdef AES_INV_CTRL_CBC_EN
    input  logic              iv_valid,
    output logic              iv_ready,
    input  logic [127:0]      iv,
    input  logic              cbc_en,
`endif
    input  logic [127:0]      core_text_out
);

    typedef enum logic [2:0] {IDLE, KEY_LD, KEY_WAIT, DEC_LD, DEC_WAIT} state_t;

    localparam int WD_W = $clog2(TMO_CYCLES) + 1;

    state_t            state_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic [WD_W-1:0]   wdog_next;
    logic              wdog_hit;
    logic              iv_pending;
    logic [127:0]      plain_next;

    // wdog_reg counts completed wait cycles, so the hit fires on the TMO_CYCLES-th one
    assign wdog_next = wdog_reg + WD_W'(1);
    assign wdog_hit  = (wdog_next == WD_W'(TMO_CYCLES));

    assign busy      = (state_reg != IDLE);
    assign key_ready = (state_reg == IDLE);

`ifdef AES_INV_CTRL_CBC_EN
    logic [127:0] chain_reg;
    logic         cbc_blk_reg;

    assign iv_ready   = (state_reg == IDLE);
    assign iv_pending = iv_valid;
    assign plain_next = cbc_blk_reg ? (core_text_out ^ chain_reg) : core_text_out;

    // Mode is captured per block so a cbc_en change mid-decrypt cannot corrupt the chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_reg   <= '0;
            cbc_blk_reg <= 1'b0;
        end else begin
            if (din_valid && din_ready)
                cbc_blk_reg <= cbc_en;
            if (iv_valid && iv_ready)
                chain_reg <= iv;
            else if (state_reg == DEC_WAIT && core_done && cbc_blk_reg)
                chain_reg <= core_text_in;
        end
    end
`else
    assign iv_pending = 1'b0;
    assign plain_next = core_text_out;
`endif

    assign din_ready = (state_reg == IDLE) && key_loaded && !dout_valid &&
                       !key_valid && !err_tmo && !iv_pending;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            wdog_reg     <= '0;
            dout_valid   <= 1'b0;
            dout         <= '0;
            key_loaded   <= 1'b0;
            err_tmo      <= 1'b0;
            blk_cnt      <= '0;
            core_kld     <= 1'b0;
            core_ld      <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
        end else begin
            core_kld <= 1'b0;
            core_ld  <= 1'b0;
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;
            // A timeout below overrides this clear when both land in the same cycle
            if (err_clr)
                err_tmo <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (key_valid) begin
                        core_key   <= key_in;
                        key_loaded <= 1'b0;
                        core_kld   <= 1'b1;
                        state_reg  <= KEY_LD;
                    end else if (din_valid && din_ready) begin
                        core_text_in <= din;
                        core_ld      <= 1'b1;
                        state_reg    <= DEC_LD;
                    end
                end
                KEY_LD: begin
                    wdog_reg  <= '0;
                    state_reg <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (core_kdone) begin
                        key_loaded <= 1'b1;
                        state_reg  <= IDLE;
                    end else if (wdog_hit) begin
                        err_tmo    <= 1'b1;
                        key_loaded <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        wdog_reg <= wdog_next;
                    end
                end
                DEC_LD: begin
                    wdog_reg  <= '0;
                    state_reg <= DEC_WAIT;
                end
                DEC_WAIT: begin
                    if (core_done) begin
                        dout       <= plain_next;
                        dout_valid <= 1'b1;
                        blk_cnt    <= blk_cnt + CNT_W'(1);
                        state_reg  <= IDLE;
                    end else if (wdog_hit) begin
                        err_tmo    <= 1'b1;
                        key_loaded <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        wdog_reg <= wdog_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench for aes_inv_cipher_ctrl with a behavioural core model (fixed load/decrypt latency).
// CBC scenario is compiled only when AES_INV_CTRL_CBC_EN is defined.
module tb_aes_inv_cipher_ctrl;

    localparam int TMO   = 16;
    localparam int CNT_W = 4;
    localparam int LAT   = 5;
    localparam int KLAT  = 3;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] K6  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV6 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C6  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P6  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] R6  = 128'h6bc0bce12a459991e134741a7f9e1925;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              key_valid = 1'b0;
    logic              key_ready;
    logic [127:0]      key_in = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [127:0]      din = '0;
    logic              dout_valid;
    logic              dout_ready = 1'b1;
    logic [127:0]      dout;
    logic              busy;
    logic              key_loaded;
    logic              err_tmo;
    logic              err_clr = 1'b0;
    logic [CNT_W-1:0]  blk_cnt;
    logic              core_kld;
    logic              core_ld;
    logic [127:0]      core_key;
    logic [127:0]      core_text_in;
    logic              core_kdone = 1'b0;
    logic              core_done = 1'b0;
    logic [127:0]      core_text_out = '0;
`ifdef AES_INV_CTRL_CBC_EN
    logic              iv_valid = 1'b0;
    logic              iv_ready;
    logic [127:0]      iv = '0;
    logic              cbc_en = 1'b0;
`endif

    int                n_tests = 0;
    int                n_fail = 0;
    int                cyc = 0;
    logic [127:0]      exp_q[$];
    logic [127:0]      cur_key = '0;
    logic [CNT_W-1:0]  exp_cnt = '0;
    bit                hang = 1'b0;

    aes_inv_cipher_ctrl #(.TMO_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .busy(busy), .key_loaded(key_loaded), .err_tmo(err_tmo), .err_clr(err_clr),
        .blk_cnt(blk_cnt),
        .core_kld(core_kld), .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_kdone(core_kdone), .core_done(core_done),
`ifdef AES_INV_CTRL_CBC_EN
        .iv_valid(iv_valid), .iv_ready(iv_ready), .iv(iv), .cbc_en(cbc_en),
`endif
        .core_text_out(core_text_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the AES core: known-answer vectors plus a keyed scramble for everything else
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
        if (k == K1 && c == C1) return P1;
        if (k == K6 && c == C6) return R6;
        return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0ff0_a5a5_f00f_1234_5678_9abc_def0;
    endfunction

    logic [127:0] m_key = '0;
    logic [127:0] m_ct = '0;
    int           kcnt = 0;
    int           dcnt = 0;

    // done arrives LAT cycles after the ld cycle, kdone KLAT cycles after kld
    always @(posedge clk) begin
        core_kdone <= 1'b0;
        core_done  <= 1'b0;
        if (core_kld) begin
            m_key <= core_key;
            kcnt  <= KLAT - 1;
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_kdone <= 1'b1;
        end
        if (core_ld && !hang) begin
            m_ct <= core_text_in;
            dcnt <= LAT - 1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                core_done     <= 1'b1;
                core_text_out <= core_fn(m_key, m_ct);
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_key(input logic [127:0] k);
        int n = 0;
        @(negedge clk);
        key_in = k;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 400) begin @(negedge clk); #1; n++; end
        n_tests++;
        if (!key_ready) begin
            n_fail++;
            $display("FAIL key_accept: key_ready=%0b required 1", key_ready);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        cur_key = k;
        n = 0;
        while (!key_loaded && n < 400) begin @(negedge clk); n++; end
        n_tests++;
        if (!key_loaded) begin
            n_fail++;
            $display("FAIL key_load: key_loaded=%0b required 1", key_loaded);
        end else begin
            $display("[TB] key %h loaded", k);
        end
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] exp_val,
                              input bit push, output int hs_cyc);
        int n = 0;
        @(negedge clk);
        din = ct;
        din_valid = 1'b1;
        #1;
        while (!din_ready && n < 400) begin @(negedge clk); #1; n++; end
        n_tests++;
        if (!din_ready) begin
            n_fail++;
            $display("FAIL din_accept: din_ready=%0b required 1", din_ready);
        end
        hs_cyc = cyc;
        if (push) exp_q.push_back(exp_val);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // Waits for the next output, pops the scoreboard and lets the handshake complete
    task automatic drain_one(input string name, output int v_cyc);
        int n = 0;
        logic [127:0] e;
        @(negedge clk);
        while (!dout_valid && n < 400) begin @(negedge clk); n++; end
        v_cyc = cyc;
        n_tests++;
        if (!dout_valid) begin
            n_fail++;
            $display("FAIL %s_out: dout_valid=0 required 1", name);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_out: dout=%h with empty scoreboard", name, dout);
        end else begin
            e = exp_q.pop_front();
            exp_cnt = exp_cnt + 1'b1;
            if (dout !== e) begin
                n_fail++;
                $display("FAIL %s_out: dout=%h required %h", name, dout, e);
            end else begin
                $display("[TB] %s dout=%h blk_cnt=%0d", name, dout, blk_cnt);
            end
            n_tests++;
            if (blk_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL %s_cnt: blk_cnt=%0d required %0d", name, blk_cnt, exp_cnt);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({dout_valid, busy, key_loaded, err_tmo, core_kld, core_ld, din_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: %b required 0000000",
                     {dout_valid, busy, key_loaded, err_tmo, core_kld, core_ld, din_ready});
        end
        n_tests++;
        if ((dout | core_key | core_text_in) !== 128'b0 || blk_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_data: dout=%h key=%h text=%h cnt=%0d required all 0",
                     dout, core_key, core_text_in, blk_cnt);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%0b key_loaded=%0b required 0 0", busy, key_loaded);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_ecb();
        int hs, vc;
        send_key(K1);
        send_block(C1, P1, 1'b1, hs);
        drain_one("ecb", vc);
        n_tests++;
        if (vc - hs != LAT + 2) begin
            n_fail++;
            $display("FAIL ecb_latency: %0d cycles required %0d", vc - hs, LAT + 2);
        end
    endtask

    task automatic test_backpressure();
        int hs, vc, n = 0, bad = 0;
        logic [127:0] b1, b2, held;
        b1 = rnd128();
        b2 = rnd128();
        dout_ready = 1'b0;
        send_block(b1, core_fn(cur_key, b1), 1'b1, hs);
        while (!dout_valid && n < 400) begin @(negedge clk); n++; end
        held = dout;
        din = b2;
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout !== held || dout_valid !== 1'b1 || din_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || n >= 400) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles required 0 (dout=%h held=%h din_ready=%0b)",
                     bad, dout, held, din_ready);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        drain_one("bp_first", vc);
        send_block(b2, core_fn(cur_key, b2), 1'b1, hs);
        drain_one("bp_second", vc);
    endtask

    task automatic test_priority();
        int hs, vc, n = 0;
        logic [127:0] ct;
        ct = rnd128();
        @(negedge clk);
        key_in = K2;
        key_valid = 1'b1;
        din = ct;
        din_valid = 1'b1;
        #1;
        n_tests++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_din_ready: din_ready=%0b required 0", din_ready);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        cur_key = K2;
        @(negedge clk);
        while (!core_kld && !core_ld && n < 50) begin @(negedge clk); n++; end
        n_tests++;
        if (core_kld !== 1'b1 || core_ld !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_order: kld=%0b ld=%0b required 1 0", core_kld, core_ld);
        end
        send_block(ct, core_fn(K2, ct), 1'b1, hs);
        drain_one("prio", vc);
    endtask

    task automatic test_back_to_back();
        int hs, vc;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) begin
            ct = rnd128();
            send_block(ct, core_fn(cur_key, ct), 1'b1, hs);
            drain_one("b2b", vc);
        end
    endtask

    task automatic test_timeout();
        int hs;
        logic [CNT_W-1:0] cnt0;
        cnt0 = blk_cnt;
        hang = 1'b1;
        send_block(rnd128(), '0, 1'b0, hs);
        @(negedge clk);
        n_tests++;
        if (core_ld !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_ld: core_ld=%0b required 1", core_ld);
        end
        repeat (16) @(negedge clk);
        n_tests++;
        if (err_tmo !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early: err_tmo=%0b busy=%0b required 0 1", err_tmo, busy);
        end
        @(negedge clk);
        n_tests++;
        if (err_tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_set: err_tmo=%0b required 1", err_tmo);
        end
        n_tests++;
        if ({busy, key_loaded, dout_valid} !== 3'b0 || blk_cnt !== cnt0) begin
            n_fail++;
            $display("FAIL tmo_state: busy/key_loaded/dout_valid=%b cnt=%0d required 000 %0d",
                     {busy, key_loaded, dout_valid}, blk_cnt, cnt0);
        end
        hang = 1'b0;
        send_key(K1);
        @(negedge clk);
        n_tests++;
        if (err_tmo !== 1'b1 || din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_block: err_tmo=%0b din_ready=%0b required 1 0", err_tmo, din_ready);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (err_tmo !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_clear: err_tmo=%0b din_ready=%0b required 0 1", err_tmo, din_ready);
        end
        $display("[TB] timeout checked");
    endtask

    task automatic test_reset_mid();
        int hs, bad = 0;
        send_block(rnd128(), '0, 1'b0, hs);
        @(negedge clk);
        n_tests++;
        if (core_ld !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_ld: core_ld=%0b required 1", core_ld);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({dout_valid, busy, key_loaded, err_tmo, core_kld, core_ld} !== 6'b0 ||
            blk_cnt !== '0 || (dout | core_key | core_text_in) !== 128'b0) begin
            n_fail++;
            $display("FAIL rmid_reset: flags=%b cnt=%0d dout=%h required all 0",
                     {dout_valid, busy, key_loaded, err_tmo, core_kld, core_ld}, blk_cnt, dout);
        end
        @(negedge clk);
        rstn = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || blk_cnt !== '0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rmid_late_done: %0d bad cycles required 0", bad);
        end
        $display("[TB] reset mid-decrypt checked");
    endtask

`ifdef AES_INV_CTRL_CBC_EN
    task automatic test_cbc();
        int hs, vc;
        logic [127:0] c7, c8, c9;
        c7 = rnd128();
        c8 = rnd128();
        c9 = rnd128();
        send_key(K6);
        @(negedge clk);
        iv = IV6;
        iv_valid = 1'b1;
        @(posedge clk); #1;
        iv_valid = 1'b0;
        cbc_en = 1'b1;
        send_block(C6, P6, 1'b1, hs);
        drain_one("cbc_kat", vc);
        send_block(c7, core_fn(K6, c7) ^ C6, 1'b1, hs);
        drain_one("cbc_chain", vc);
        cbc_en = 1'b0;
        send_block(c8, core_fn(K6, c8), 1'b1, hs);
        drain_one("cbc_ecb", vc);
        cbc_en = 1'b1;
        send_block(c9, core_fn(K6, c9) ^ c7, 1'b1, hs);
        drain_one("cbc_resume", vc);
    endtask
`endif

    initial begin
        test_reset();
        test_ecb();
        test_backpressure();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef AES_INV_CTRL_CBC_EN
        test_cbc();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
